// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: FSM states and local opcodes.
package seq_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_JMP  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_PAUSE,
    S_HALTED,
    S_ERROR
  } state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Cycle counter bounding the wait for processor done; flags the final waiting cycle.
module seq_timeout_ctr #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted on the cycle whose increment would make LIMIT cycles of waiting.
  assign hit = enable && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/program_sequencer.sv
// Fetches instruction words from a synchronous ROM and feeds them to the processor,
// handling JMP/HALT locally, with free-run and single-step modes.
module program_sequencer #(
  parameter int unsigned AW       = 8,
  parameter int unsigned PROG_LEN = 256,
  parameter int unsigned OPC_LSB  = 13,
  parameter logic [2:0]  OPC_JMP  = seq_pkg::OPC_JMP,
  parameter logic [2:0]  OPC_HALT = seq_pkg::OPC_HALT,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic [15:0]   proc_din,
  output logic          proc_run,
  input  logic          proc_done,
  output logic          busy,
  output logic          halted,
  output logic          err_timeout,
  output logic [AW-1:0] pc,
  output logic [15:0]   instr_count
);

  import seq_pkg::*;

  localparam logic [AW:0] PROG_END = (AW + 1)'(PROG_LEN);

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     icnt_q, icnt_d;
  logic [OPC_W-1:0] op;
  logic [AW:0]     pc_inc;
  logic [AW:0]     target;
  logic            tmo_clear, tmo_en, tmo_hit;

  assign op     = rom_data[OPC_LSB +: OPC_W];
  // One extra bit lets a single compare catch both pc == PROG_LEN and a wrap to 0.
  assign pc_inc = {1'b0, pc_q} + (AW + 1)'(1);
  assign target = {1'b0, rom_data[AW-1:0]};

  seq_timeout_ctr #(
    .W     (4),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (clk_50MHz),
    .rst_n  (reset_n),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .hit    (tmo_hit)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    icnt_d    = icnt_q;
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = rom_data;
        if (op == OPC_HALT) begin
          state_d = S_HALTED;
        end else if (op == OPC_JMP) begin
          pc_d    = rom_data[AW-1:0];
          state_d = (target >= PROG_END) ? S_HALTED : S_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_clear = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        tmo_en = 1'b1;
        if (proc_done) begin
          icnt_d = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;
          pc_d   = pc_inc[AW-1:0];
          if (pc_inc == PROG_END)  state_d = S_HALTED;
          else if (step_mode)      state_d = S_PAUSE;
          else                     state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      S_PAUSE: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      icnt_q  <= icnt_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign proc_din    = instr_q;
  assign instr_count = icnt_q;
  assign proc_run    = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);
  assign err_timeout = (state_q == S_ERROR);
  assign busy        = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: default build plus two short-program builds.
module tb_program_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start, step_mode, step;
  logic        start5;

  logic [7:0]  rom_addr0;
  logic [15:0] rom_data0, proc_din0, ic0;
  logic        proc_run0, proc_done0, busy0, halted0, err0;
  logic [7:0]  pc0;

  logic [7:0]  rom_addr1, pc1;
  logic [15:0] rom_data1, proc_din1, ic1;
  logic        proc_run1, proc_done1, busy1, halted1, err1;

  logic [1:0]  rom_addr2, pc2;
  logic [15:0] rom_data2, proc_din2, ic2;
  logic        proc_run2, proc_done2, busy2, halted2, err2;

  logic [15:0] rom0 [256];

  int          vectors = 0;
  int          errs    = 0;

  // processor model state
  bit          done_en  = 1'b1;
  int          done_lat = 2;
  bit          stray    = 1'b0;
  logic [7:0]  hist0 = '0, hist1 = '0, hist2 = '0;
  int          run_cnt = 0, run1 = 0, run2 = 0;
  int          cyc = 0;
  logic [15:0] issued [$];
  int          issue_cyc [$];

  program_sequencer u0 (
    .clk_50MHz(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .proc_din(proc_din0), .proc_run(proc_run0),
    .proc_done(proc_done0), .busy(busy0), .halted(halted0), .err_timeout(err0),
    .pc(pc0), .instr_count(ic0)
  );

  program_sequencer #(.AW(8), .PROG_LEN(4)) u1 (
    .clk_50MHz(clk), .reset_n(reset_n), .start(start5), .step_mode(1'b0), .step(1'b0),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .proc_din(proc_din1), .proc_run(proc_run1),
    .proc_done(proc_done1), .busy(busy1), .halted(halted1), .err_timeout(err1),
    .pc(pc1), .instr_count(ic1)
  );

  program_sequencer #(.AW(2), .PROG_LEN(4)) u2 (
    .clk_50MHz(clk), .reset_n(reset_n), .start(start5), .step_mode(1'b0), .step(1'b0),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .proc_din(proc_din2), .proc_run(proc_run2),
    .proc_done(proc_done2), .busy(busy2), .halted(halted2), .err_timeout(err2),
    .pc(pc2), .instr_count(ic2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous ROMs
  always @(posedge clk) begin
    rom_data0 <= rom0[rom_addr0];
    rom_data1 <= {8'h50, rom_addr1};
    rom_data2 <= {14'h0a00, rom_addr2};
  end

  // processor models and run-pulse monitor
  initial begin
    proc_done0 = 1'b0;
    proc_done1 = 1'b0;
    proc_done2 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      hist0 = {hist0[6:0], proc_run0};
      hist1 = {hist1[6:0], proc_run1};
      hist2 = {hist2[6:0], proc_run2};
      if (proc_run0) begin
        run_cnt++;
        issued.push_back(proc_din0);
        issue_cyc.push_back(cyc);
      end
      if (proc_run1) run1++;
      if (proc_run2) run2++;
      proc_done0 = stray || (done_en && hist0[done_lat]);
      proc_done1 = hist1[1];
      proc_done2 = hist2[1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic pulse_stray();
    @(posedge clk);
    #2 stray = 1'b1;
    @(posedge clk);
    #2 stray = 1'b0;
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_run(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (proc_run0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_mon();
    run_cnt = 0;
    issued.delete();
    issue_cyc.delete();
  endtask

  initial begin
    bit ok;
    reset_n   = 1'b0;
    start     = 1'b0;
    start5    = 1'b0;
    step      = 1'b0;
    step_mode = 1'b0;
    for (int i = 0; i < 256; i++) rom0[i] = 16'h0000;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy0, halted0, err0, proc_run0}, 4'b0000);
    chk("rst_pc_icnt", {pc0, ic0}, 24'h0);
    chk("rst_addr_din", {rom_addr0, proc_din0}, 24'h0);
    chk("rst_u1_u2", {busy1, halted1, err1, proc_run1, busy2, halted2, err2, proc_run2}, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // three normal instructions then HALT
    rom0[0] = 16'h1111; rom0[1] = 16'h2222; rom0[2] = 16'h3333; rom0[3] = 16'hE000;
    clear_mon();
    pulse_start();
    wait_halt(200, ok);
    chk("t1_halt_reached", ok, 1);
    chk("t1_runs", run_cnt, 3);
    chk("t1_icnt", ic0, 16'd3);
    chk("t1_pc", pc0, 8'd3);
    chk("t1_flags", {busy0, halted0, err0}, 3'b010);
    if (issued.size() == 3) begin
      chk("t1_din0", issued[0], 16'h1111);
      chk("t1_din1", issued[1], 16'h2222);
      chk("t1_din2", issued[2], 16'h3333);
      chk("t1_turnaround", issue_cyc[1] - issue_cyc[0], 5);
    end

    // JMP 5 skips ROM[1..4]
    rom0[0] = 16'hC005; rom0[5] = 16'h4545; rom0[6] = 16'hE000;
    clear_mon();
    pulse_start();
    wait_halt(200, ok);
    chk("t2_halt_reached", ok, 1);
    chk("t2_runs", run_cnt, 1);
    chk("t2_pc", pc0, 8'd6);
    chk("t2_icnt", ic0, 16'd1);
    if (issued.size() == 1) chk("t2_din", issued[0], 16'h4545);

    // done never comes -> timeout
    rom0[0] = 16'h0ABC; rom0[1] = 16'hE000;
    done_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_run(50, ok);
    chk("t3_run_seen", ok, 1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t3_before_limit", {busy0, err0}, 2'b10);
    @(negedge clk);
    chk("t3_at_limit", {busy0, halted0, err0}, 3'b001);
    chk("t3_pc_held", pc0, 8'd0);
    chk("t3_icnt", ic0, 16'd0);
    done_en = 1'b1;
    pulse_start();
    chk("t3_restart", {busy0, err0, pc0}, {2'b10, 8'd0});
    wait_halt(200, ok);
    chk("t3_rerun_halt", ok, 1);
    chk("t3_rerun_state", {pc0, ic0}, {8'd1, 16'd1});

    // single-step mode
    rom0[0] = 16'h1111; rom0[1] = 16'h2222; rom0[2] = 16'h3333; rom0[3] = 16'hE000;
    step_mode = 1'b1;
    clear_mon();
    pulse_start();
    wait_run(50, ok);
    chk("t4_first_run", ok, 1);
    repeat (20) @(negedge clk);
    chk("t4_pause1", {run_cnt[7:0], ic0, pc0, busy0}, {8'd1, 16'd1, 8'd1, 1'b1});
    pulse_stray();
    repeat (3) @(negedge clk);
    chk("t4_stray_ignored", {ic0, pc0}, {16'd1, 8'd1});
    pulse_step();
    repeat (20) @(negedge clk);
    chk("t4_pause2", {run_cnt[7:0], ic0, pc0}, {8'd2, 16'd2, 8'd2});
    pulse_step();
    repeat (20) @(negedge clk);
    chk("t4_pause3", {run_cnt[7:0], ic0, pc0}, {8'd3, 16'd3, 8'd3});
    pulse_step();
    repeat (5) @(negedge clk);
    chk("t4_halt", {run_cnt[7:0], halted0, busy0}, {8'd3, 2'b10});
    step_mode = 1'b0;

    // program length limit, with and without pc wrap
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    repeat (60) @(negedge clk);
    chk("t5_u1_halt", {halted1, err1, pc1}, {2'b10, 8'd4});
    chk("t5_u1_count", {ic1, run1[7:0]}, {16'd4, 8'd4});
    chk("t5_u2_halt", {halted2, err2, pc2}, {2'b10, 2'd0});
    chk("t5_u2_count", {ic2, run2[7:0]}, {16'd4, 8'd4});

    // asynchronous reset during EXEC, then stray done in IDLE
    rom0[0] = 16'h0ABC;
    done_en = 1'b0;
    pulse_start();
    wait_run(50, ok);
    chk("t6_run_seen", ok, 1);
    @(negedge clk);
    chk("t6_in_exec", {busy0, proc_run0}, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_flags", {busy0, halted0, err0, proc_run0}, 4'b0000);
    chk("t6_async_regs", {pc0, ic0, rom_addr0, proc_din0}, 48'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_en = 1'b1;
    pulse_stray();
    repeat (3) @(negedge clk);
    chk("t6_idle_stray", {busy0, pc0, ic0}, {1'b0, 8'd0, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
